// File: rtl/ts_injection_scheduler_param.sv
// Injection scheduler: derives the slot index from global time, reads the slot
// table once per slot and queues valid injection addresses into a small FIFO.
module ts_injection_scheduler_param #(
  parameter int TIME_W     = 48,
  parameter int SLOT_LEN_W = 11,
  parameter int SLOT_W     = 10,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [1:0]            iv_cfg_finish,
  input  logic [TIME_W-1:0]     iv_syned_global_time,
  input  logic [SLOT_LEN_W-1:0] iv_time_slot_length,
  input  logic [SLOT_W:0]       iv_table_period,
  output logic [SLOT_W-1:0]     ov_time_slot,
  output logic                  o_time_slot_switch,
  output logic [ADDR_W-1:0]     ov_ts_injection_addr,
  output logic                  o_ts_injection_addr_wr,
  input  logic                  i_ts_injection_addr_ack,
  input  logic [DATA_W-1:0]     iv_table_wdata,
  input  logic                  i_table_wr,
  input  logic [SLOT_W-1:0]     iv_table_addr,
  input  logic                  i_table_rd,
  output logic [DATA_W-1:0]     ov_table_rdata,
  output logic                  o_table_rdata_valid,
  output logic [1:0]            ov_ism_state,
  output logic [15:0]           ov_overflow_cnt
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DISABLED = 2'd2} state_t;

  state_t                  r_state;
  logic [DATA_W-1:0]       r_mem [0:(1<<SLOT_W)-1];
  logic [DATA_W-1:0]       r_rdata_a;
  logic                    r_time_b10;
  logic [SLOT_LEN_W-1:0]   r_tick_cnt;
  logic [ADDR_W-1:0]       r_fifo [0:FIFO_DEPTH-1];
  logic [PTR_W-1:0]        r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]          r_count;

  logic                    w_en, w_tick, w_slot_end, w_slot_wrap, w_rd_a;
  logic                    w_full, w_pop, w_push, w_push_ok, w_drop;
  logic [SLOT_LEN_W-1:0]   w_len_m1;
  logic [SLOT_W:0]         w_per_m1;
  logic                    w_unused;

  assign w_en        = (iv_cfg_finish == 2'b11);
  // bit 10 toggles every 1024 ns; any jump collapses to a single tick
  assign w_tick      = iv_syned_global_time[10] ^ r_time_b10;
  assign w_len_m1    = (iv_time_slot_length == '0) ? '0 : iv_time_slot_length - SLOT_LEN_W'(1);
  assign w_per_m1    = (iv_table_period == '0) ? '0 : iv_table_period - (SLOT_W+1)'(1);
  assign w_slot_end  = (r_tick_cnt >= w_len_m1);
  assign w_slot_wrap = ({1'b0, ov_time_slot} >= w_per_m1);
  assign w_rd_a      = w_en && (r_state == IDLE) && o_time_slot_switch;

  assign w_full      = (r_count == FULL_CNT);
  assign w_pop       = i_ts_injection_addr_ack && (r_count != '0);
  assign w_push      = w_en && (r_state == READ) && r_rdata_a[DATA_W-1];
  assign w_push_ok   = w_push && (!w_full || w_pop);
  assign w_drop      = w_push && w_full && !w_pop;

  assign o_ts_injection_addr_wr = (r_count != '0);
  assign ov_ts_injection_addr   = o_ts_injection_addr_wr ? r_fifo[r_rd_ptr] : '0;
  assign ov_ism_state           = r_state;
  assign w_unused = ^{iv_syned_global_time[TIME_W-1:11], iv_syned_global_time[9:0],
                      r_rdata_a[DATA_W-2:ADDR_W]};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_time_b10         <= 1'b0;
      r_tick_cnt         <= '0;
      ov_time_slot       <= '0;
      o_time_slot_switch <= 1'b0;
    end else begin
      r_time_b10         <= iv_syned_global_time[10];
      o_time_slot_switch <= 1'b0;
      if (!w_en) begin
        r_tick_cnt   <= '0;
        ov_time_slot <= '0;
      end else if (w_tick) begin
        if (w_slot_end) begin
          r_tick_cnt         <= '0;
          ov_time_slot       <= w_slot_wrap ? '0 : ov_time_slot + SLOT_W'(1);
          o_time_slot_switch <= 1'b1;
        end else begin
          r_tick_cnt <= r_tick_cnt + SLOT_LEN_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= DISABLED;
    end else if (!w_en) begin
      r_state <= DISABLED;
    end else begin
      case (r_state)
        DISABLED: r_state <= IDLE;
        IDLE:     if (o_time_slot_switch) r_state <= READ;
        READ:     r_state <= IDLE;
        default:  r_state <= DISABLED;
      endcase
    end
  end

  // Table storage is not reset; NBA ordering gives read-first on collisions.
  always_ff @(posedge i_clk) begin
    if (i_table_wr) r_mem[iv_table_addr] <= iv_table_wdata;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rdata_a           <= '0;
      ov_table_rdata      <= '0;
      o_table_rdata_valid <= 1'b0;
    end else begin
      o_table_rdata_valid <= i_table_rd;
      if (i_table_rd) ov_table_rdata <= r_mem[iv_table_addr];
      if (w_rd_a)     r_rdata_a      <= r_mem[ov_time_slot];
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_fifo[r_wr_ptr] <= r_rdata_a[ADDR_W-1:0];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      ov_overflow_cnt <= '0;
    end else begin
      if (w_drop && ov_overflow_cnt != 16'hFFFF) ov_overflow_cnt <= ov_overflow_cnt + 16'd1;
      if (!w_en) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        case ({w_push_ok, w_pop})
          2'b10:   r_count <= r_count + (PTR_W+1)'(1);
          2'b01:   r_count <= r_count - (PTR_W+1)'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ts_injection_scheduler_param.sv
// Directed bench for ts_injection_scheduler_param: a queue-based reference model
// checked every cycle, plus hand-computed literal checks at key points.
module tb_ts_injection_scheduler_param;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  cfg = 2'b00;
  logic [47:0] tval = '0;
  logic [10:0] len = 11'd2;
  logic [10:0] per = 11'd3;
  logic        ack = 1'b0;
  logic [15:0] wdata = '0;
  logic        twr = 1'b0;
  logic [9:0]  taddr = '0;
  logic        trd = 1'b0;
  logic [9:0]  slot;
  logic        sw;
  logic [4:0]  iaddr;
  logic        iwr;
  logic [15:0] rdata;
  logic        rdv;
  logic [1:0]  state;
  logic [15:0] ovf;

  always #5 clk = ~clk;

  ts_injection_scheduler_param dut (
    .i_clk(clk), .i_rst(rst), .iv_cfg_finish(cfg), .iv_syned_global_time(tval),
    .iv_time_slot_length(len), .iv_table_period(per),
    .ov_time_slot(slot), .o_time_slot_switch(sw),
    .ov_ts_injection_addr(iaddr), .o_ts_injection_addr_wr(iwr),
    .i_ts_injection_addr_ack(ack),
    .iv_table_wdata(wdata), .i_table_wr(twr), .iv_table_addr(taddr), .i_table_rd(trd),
    .ov_table_rdata(rdata), .o_table_rdata_valid(rdv),
    .ov_ism_state(state), .ov_overflow_cnt(ovf)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: slot arithmetic on tick counts, a queue for the FIFO,
  // a shadow copy of the table, and a one-slot "read in flight" record.
  logic [15:0] sh [0:1023];
  int          m_slot = 0, m_cnt = 0, m_st = 2, m_ovf = 0;
  bit          m_sw = 0, m_b10 = 0, m_rdv = 0, m_inflight = 0;
  logic [15:0] m_rd = '0, m_rdata = '0;
  logic [4:0]  m_q [$];

  initial begin
    for (int i = 0; i < 1024; i++) sh[i] = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_slot = 0; m_cnt = 0; m_st = 2; m_ovf = 0; m_sw = 0; m_b10 = 0;
        m_rdv = 0; m_rdata = '0; m_inflight = 0; m_q.delete();
      end else begin
        bit tick;
        int lm1, pm1;
        tick = (tval[10] != m_b10);
        if (cfg != 2'b11) begin
          m_slot = 0; m_cnt = 0; m_sw = 0; m_st = 2; m_inflight = 0; m_q.delete();
        end else begin
          if (ack && m_q.size() != 0) void'(m_q.pop_front());
          if (m_inflight && m_rd[15]) begin
            if (m_q.size() < DEPTH) m_q.push_back(m_rd[4:0]);
            else if (m_ovf < 65535) m_ovf++;
          end
          m_inflight = 0;
          if (m_st == 2) m_st = 0;
          else if (m_st == 1) m_st = 0;
          else if (m_sw) begin
            m_rd = sh[m_slot];
            m_inflight = 1;
            m_st = 1;
          end
          m_sw = 0;
          if (tick) begin
            lm1 = (len == 0) ? 0 : int'(len) - 1;
            pm1 = (per == 0) ? 0 : int'(per) - 1;
            if (m_cnt >= lm1) begin
              m_cnt = 0;
              m_slot = (m_slot >= pm1) ? 0 : m_slot + 1;
              m_sw = 1;
            end else m_cnt++;
          end
        end
        m_b10 = tval[10];
        m_rdv = trd;
        if (trd) m_rdata = sh[taddr];
        if (twr) sh[taddr] = wdata;
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (!rst) begin
      chk("slot", 64'(slot), 64'(m_slot));
      chk("switch", 64'(sw), 64'(m_sw));
      chk("inj_wr", 64'(iwr), 64'(m_q.size() != 0));
      if (m_q.size() != 0) chk("inj_addr", 64'(iaddr), 64'(m_q[0]));
      chk("state", 64'(state), 64'(m_st));
      chk("overflow", 64'(ovf), 64'(m_ovf));
      chk("rd_valid", 64'(rdv), 64'(m_rdv));
      if (m_rdv) chk("rdata", 64'(rdata), 64'(m_rdata));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk);
    tval = tval + 48'd1024;
  endtask

  task automatic host_wr(input logic [9:0] a, input logic [15:0] d);
    @(negedge clk);
    twr = 1'b1; taddr = a; wdata = d;
    @(negedge clk);
    twr = 1'b0;
  endtask

  task automatic post_edge();
    @(posedge clk); #2;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_slot"}, 64'(slot), 64'd0);
    chk({tag, "_switch"}, 64'(sw), 64'd0);
    chk({tag, "_wr"}, 64'(iwr), 64'd0);
    chk({tag, "_addr"}, 64'(iaddr), 64'd0);
    chk({tag, "_state"}, 64'(state), 64'd2);
    chk({tag, "_ovf"}, 64'(ovf), 64'd0);
    chk({tag, "_rdv"}, 64'(rdv), 64'd0);
    chk({tag, "_rdata"}, 64'(rdata), 64'd0);
  endtask

  initial begin
    cyc(3);
    chk_all_zero("reset");
    rst = 1'b0;
    for (int a = 0; a < 8; a++) host_wr(10'(a), 16'h0000);
    host_wr(10'd1, 16'h8005);
    host_wr(10'd2, 16'h0007);

    // slot length 2, period 3
    @(negedge clk); cfg = 2'b11;
    cyc(2);
    chk("enable_idle", 64'(state), 64'd0);
    tick(); cyc(3);
    chk("first_tick_no_switch", 64'(slot), 64'd0);
    tick(); post_edge();
    chk("slot1_switch", 64'(sw), 64'd1);
    chk("slot1_idx", 64'(slot), 64'd1);
    post_edge();
    chk("slot1_read_state", 64'(state), 64'd1);
    chk("slot1_wr_not_yet", 64'(iwr), 64'd0);
    post_edge();
    chk("slot1_wr", 64'(iwr), 64'd1);
    chk("slot1_addr", 64'(iaddr), 64'd5);
    @(negedge clk); ack = 1'b1;
    @(negedge clk); ack = 1'b0;
    chk("slot1_acked", 64'(iwr), 64'd0);
    tick(); cyc(3);
    chk("slot1_hold", 64'(slot), 64'd1);
    tick(); post_edge();
    chk("slot2_idx", 64'(slot), 64'd2);
    cyc(3);
    chk("slot2_invalid_no_push", 64'(iwr), 64'd0);
    tick(); cyc(3);
    tick(); post_edge();
    chk("wrap_idx", 64'(slot), 64'd0);
    chk("wrap_switch", 64'(sw), 64'd1);
    cyc(3);

    // overflow: six valid slots, no acks
    for (int k = 1; k < 8; k++) host_wr(10'(k), 16'h8000 | 16'(k + 10));
    @(negedge clk); len = 11'd1; per = 11'd8;
    repeat (6) begin tick(); cyc(4); end
    chk("ovf_count", 64'(ovf), 64'd2);
    for (int i = 0; i < 4; i++) begin
      chk("drain_wr", 64'(iwr), 64'd1);
      chk("drain_addr", 64'(iaddr), 64'(11 + i));
      ack = 1'b1;
      @(negedge clk); ack = 1'b0;
    end
    chk("drained_wr", 64'(iwr), 64'd0);

    // host port
    host_wr(10'd3, 16'h8009);
    @(negedge clk); trd = 1'b1; taddr = 10'd3;
    post_edge();
    chk("host_rdv", 64'(rdv), 64'd1);
    chk("host_rdata", 64'(rdata), 64'h8009);
    @(negedge clk); twr = 1'b1; wdata = 16'h800A;
    post_edge();
    chk("collide_rdata_old", 64'(rdata), 64'h8009);
    @(negedge clk); twr = 1'b0;
    post_edge();
    chk("collide_rdata_new", 64'(rdata), 64'h800A);
    @(negedge clk); trd = 1'b0;

    // disable with two entries queued (slots 7 and 1)
    repeat (3) begin tick(); cyc(4); end
    chk("dis_pre_addr", 64'(iaddr), 64'd17);
    @(negedge clk); cfg = 2'b01;
    post_edge();
    chk("dis_wr", 64'(iwr), 64'd0);
    chk("dis_slot", 64'(slot), 64'd0);
    chk("dis_state", 64'(state), 64'd2);
    cyc(2);
    @(negedge clk); cfg = 2'b11;
    cyc(2);
    tick(); post_edge();
    chk("reen_slot", 64'(slot), 64'd1);
    cyc(3);
    chk("reen_addr", 64'(iaddr), 64'd11);
    ack = 1'b1;
    @(negedge clk); ack = 1'b0;

    // period shrunk below current slot, then zero length
    repeat (2) begin tick(); cyc(4); end
    @(negedge clk); per = 11'd2;
    tick(); post_edge();
    chk("shrink_wrap", 64'(slot), 64'd0);
    cyc(3);
    @(negedge clk); len = 11'd0;
    tick(); post_edge();
    chk("len0_switch", 64'(sw), 64'd1);
    chk("len0_slot", 64'(slot), 64'd1);
    cyc(4);

    // reset while READ
    tick(); post_edge();
    @(posedge clk); #3;
    chk("pre_rst_read", 64'(state), 64'd1);
    rst = 1'b1; tval = '0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk); rst = 1'b0;
    cyc(3);
    tick(); cyc(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ts_injection_scheduler_param.md
# ts_injection_scheduler_param

Parametrised next-generation injection scheduler for time-sensitive packets in the host receive path. Derives the injection time slot from the synchronised global time, reads a host-configurable injection slot table once per slot, and queues the valid entries' injection addresses to the flow lookup stage through a small FIFO with ack handshake. Adds three capabilities:
- per-entry valid bit;
- buffering that is safe against back-pressure, with overflow counting;
- independent host-side table read/write access.

## Interface
Parameters:
- TIME_W, 48, synchronised global time width (ns)
- SLOT_LEN_W, 11, slot-length field width (µs units)
- SLOT_W, 10, slot index width; table depth 2^SLOT_W
- ADDR_W, 5, injection address width
- DATA_W, 16, table entry width; bit DATA_W-1 = valid, bits ADDR_W-1:0 = injection address
- FIFO_DEPTH, 4, pending-address FIFO depth (power of two, ≥2)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- iv_cfg_finish  in  2  scheduling enabled only when 2'b11
- iv_syned_global_time  in  TIME_W  synchronised time, ns
- iv_time_slot_length  in  SLOT_LEN_W  slot length in µs ticks; 0 treated as 1
- iv_table_period  in  SLOT_W+1  number of slots per cycle; 0 treated as 1
- ov_time_slot  out  SLOT_W  current slot index
- o_time_slot_switch  out  1  one-cycle pulse on slot change
- ov_ts_injection_addr  out  ADDR_W  FIFO head address
- o_ts_injection_addr_wr  out  1  head valid
- i_ts_injection_addr_ack  in  1  one-cycle pop of head
- iv_table_wdata  in  DATA_W  host write data
- i_table_wr  in  1  host write strobe
- iv_table_addr  in  SLOT_W  host address
- i_table_rd  in  1  host read strobe
- ov_table_rdata  out  DATA_W  host read data
- o_table_rdata_valid  out  1  pulse, one cycle after i_table_rd
- ov_ism_state  out  2  scheduler state
- ov_overflow_cnt  out  16  saturating count of dropped entries

## Operation

**Time base**
- µs tick: iv_syned_global_time[10] differs from its registered copy. A 1024 ns tick; a time jump yields at most one tick.
- Slot counter: counts ticks. On a tick with count ≥ length-1, the count clears, ov_time_slot advances and o_time_slot_switch pulses.
- Slot wrap: ov_time_slot wraps to 0 when it is ≥ period-1. This also covers a period reduced below the current slot.

**Enable**
- While iv_cfg_finish != 2'b11: slot, counter and FIFO are held cleared, no switch pulses occur, and the FSM stays in DISABLED.
- The host table port works regardless of enable.

**Table**
- True dual-port RAM, 2^SLOT_W × DATA_W, registered read, read-first on a same-address collision.
- Port A: scheduler read only. Port B: host.
- i_table_wr and i_table_rd asserted together: write is performed; rdata returns the old contents.

**FSM** (ov_ism_state: IDLE=0, READ=1, DISABLED=2)
- DISABLED → IDLE when enabled.
- IDLE + o_time_slot_switch: issue a port-A read at ov_time_slot (the new value) → READ.
- READ: data valid. If valid bit = 1, push the address; → IDLE.
- Any state → DISABLED when enable drops.

**FIFO**
- Push when full without a same-cycle pop: entry dropped, ov_overflow_cnt +1, saturating at 0xFFFF.
- Push and pop in the same cycle on a full FIFO: both succeed, no drop.
- Head is presented as ov_ts_injection_addr with o_ts_injection_addr_wr high. The head holds until acked.
- An ack while o_ts_injection_addr_wr is low is ignored.

## Timing
- Reset values: all outputs 0; state = DISABLED.
- Slot switch pulse in the cycle after the tick edge is sampled.
- Switch pulse at cycle T:
  - T: read issued.
  - T+1: READ state, push at the end of T+1.
  - T+2: o_ts_injection_addr_wr high (FIFO previously empty).
- Ack at cycle A: next entry (if any) presented at A+1, otherwise wr low at A+1.
- Host read: rdata valid and o_table_rdata_valid high exactly 1 cycle after i_table_rd.
- Reset asserted mid-operation clears everything asynchronously.
- Counter, FIFO and FSM clear within one cycle of enable deassertion. Pending addresses are discarded.

## Test plan
- Slot length 2, period 3, enabled; advance time in 1024 ns steps → slot sequence 0,1,2,0 with a switch every 2 ticks; one pulse each.
- Table[1]=0x8005 (valid), table[2]=0x0007 (invalid) → after entering slot 1, wr rises 2 cycles after the pulse with addr 5; after entering slot 2, nothing is pushed.
- Hold ack low across 6 valid slots, FIFO_DEPTH=4 → 4 addresses queued in order, ov_overflow_cnt=2; acks drain them in order, and wr drops after the 4th.
- Host writes table[3]=0x8009, then reads addr 3 → rdata 0x8009 with valid pulse 1 cycle later. A same-cycle write/read of addr 3 with 0x800A returns 0x8009.
- Drop iv_cfg_finish to 2'b01 with 2 entries queued → wr low and slot 0 next cycle, state=2; re-enable → scheduling restarts from slot 0.
- Assert i_rst mid-READ → all outputs 0 immediately, state DISABLED.
